// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths, state encoding and address/protection helpers
package apb_pkg;

    localparam int ADDR_WIDTH    = 16;
    localparam int DATA_WIDTH    = 32;
    localparam int STRB_WIDTH    = DATA_WIDTH / 8;
    localparam int PERIPHERAL_WS = 2;
    localparam int ALIGNBITS     = $clog2(STRB_WIDTH);
    localparam int REG_ITEMS     = 2 ** (ADDR_WIDTH - ALIGNBITS);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERROR
    } state;

    function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ALIGNBITS-1:0] == '0;
    endfunction

    // The upper half of the address map is the privileged region.
    function automatic logic [2:0] getPprot(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1] ? 3'b111 : 3'b000;
    endfunction

    function automatic logic isFault(
        input logic                  write,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [STRB_WIDTH-1:0] strb,
        input logic [2:0]            pprot
    );
        return !validAlign(addr) || (pprot != getPprot(addr)) || (!write && strb != '0);
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - word register memory with byte-enabled write and combinational read
module apb_regfile #(
    parameter int ITEMS      = apb_pkg::REG_ITEMS,
    parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH,
    parameter int STRB_WIDTH = apb_pkg::STRB_WIDTH,
    parameter int IDX_W      = $clog2(ITEMS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      windex,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic [IDX_W-1:0]      rindex,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Contents are intentionally left unreset.
    logic [DATA_WIDTH-1:0] mem [ITEMS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int n = 0; n < STRB_WIDTH; n++) begin
                if (wstrb[n]) begin
                    mem[windex][8*n +: 8] <= wdata[8*n +: 8];
                end
            end
        end
    end

    assign rdata = mem[rindex];

endmodule

// File: rtl/apb_completer.sv
// rtl/apb_completer.sv - APB4 completer with wait states, fault checking and register memory
module apb_completer #(
    parameter int ADDR_WIDTH  = apb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = apb_pkg::DATA_WIDTH,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int WAIT_STATES = apb_pkg::PERIPHERAL_WS
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_WIDTH-1:0] PSTRB,
    input  logic [2:0]            PPROT,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);
    import apb_pkg::*;

    localparam int IDX_W = ADDR_WIDTH - ALIGNBITS;
    localparam int ITEMS = 2 ** IDX_W;
    localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    state                  st;
    logic [CW-1:0]         cnt;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic                  ready_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [IDX_W-1:0]      rd_index;
    logic                  access_ok;
    logic                  we;

    assign access_ok = PSEL && PENABLE;
    // Only the zero-wait-state configuration needs to read straight off the setup address.
    assign rd_index  = (st == IDLE) ? PADDR[ADDR_WIDTH-1:ALIGNBITS] : addr_q[ADDR_WIDTH-1:ALIGNBITS];
    assign we        = (st == ACCESS) && (cnt == '0) && wr_q && access_ok;

    apb_regfile #(
        .ITEMS      (ITEMS),
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk    (PCLK),
        .we     (we),
        .windex (addr_q[ADDR_WIDTH-1:ALIGNBITS]),
        .wdata  (wdata_q),
        .wstrb  (strb_q),
        .rindex (rd_index),
        .rdata  (mem_rdata)
    );

    // Output flops are loaded one edge ahead so each reflects the state being entered.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            st      <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            unique case (st)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        wr_q    <= PWRITE;
                        addr_q  <= PADDR;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                        if (isFault(PWRITE, PADDR, PSTRB, PPROT)) begin
                            st      <= ERROR;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            st  <= ACCESS;
                            cnt <= CW'(WAIT_STATES);
                            if (WAIT_STATES == 0) begin
                                ready_q <= 1'b1;
                                if (!PWRITE) rdata_q <= mem_rdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (!access_ok) begin
                        st  <= IDLE;
                        cnt <= '0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            ready_q <= 1'b1;
                            if (!wr_q) rdata_q <= mem_rdata;
                        end
                    end else begin
                        st <= IDLE;
                    end
                end
                ERROR:   st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

    assign PREADY  = ready_q;
    assign PSLVERR = err_q;
    assign PRDATA  = rdata_q;

endmodule

// File: tb/tb_apb_completer.sv
// tb/tb_apb_completer.sv - scoreboard bench for apb_completer
module tb_apb_completer;

    localparam int WS = 2;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [15:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic [2:0]  PPROT = '0;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];

    apb_completer dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PPROT   (PPROT),
        .PREADY  (PREADY),
        .PRDATA  (PRDATA),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit model_fault(input bit wr, input logic [15:0] a,
                                       input logic [3:0] s, input logic [2:0] p);
        logic [2:0] need;
        need = a[15] ? 3'b111 : 3'b000;
        return (a[1:0] != 2'b00) || (p != need) || (!wr && s != 4'h0);
    endfunction

    task automatic go_idle();
        @(negedge PCLK);
        PSEL = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic xfer(input string tag, input bit wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        exp_t        e;
        exp_t        x;
        int          idx;
        int          waits;
        bit          done;
        logic [31:0] tmp;
        idx     = int'(a[15:2]);
        e.tag   = tag;
        e.err   = model_fault(wr, a, s, p);
        e.rdata = (!wr && !e.err && model.exists(idx)) ? model[idx] : 32'h0;
        sb.push_back(e);
        if (wr && !e.err) begin
            tmp = model.exists(idx) ? model[idx] : 32'h0;
            for (int n = 0; n < 4; n++)
                if (s[n]) tmp[8*n +: 8] = d[8*n +: 8];
            model[idx] = tmp;
        end
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = a; PWDATA = d; PSTRB = s; PPROT = p;
        @(negedge PCLK);
        PENABLE = 1'b1;
        waits = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0) @(negedge PCLK);
            if (PREADY) begin
                x = sb.pop_front();
                check({x.tag, ":waits"}, waits, x.err ? 0 : WS);
                check({x.tag, ":slverr"}, {31'b0, PSLVERR}, {31'b0, x.err});
                check({x.tag, ":rdata"}, PRDATA, x.rdata);
                done = 1'b1;
            end else begin
                check({tag, ":wait_rdata"}, PRDATA, 32'h0);
                check({tag, ":wait_slverr"}, {31'b0, PSLVERR}, 32'h0);
                waits++;
                if (waits == 1) begin
                    PADDR = 16'($urandom); PWDATA = $urandom;
                    PSTRB = 4'($urandom); PWRITE = ~wr;
                end
            end
        end
        if (!done) begin
            check({tag, ":timeout"}, 32'h0, 32'h1);
            void'(sb.pop_front());
        end
    endtask

    task automatic xfer_abort(input string tag, input logic [15:0] a,
                              input logic [31:0] d, input bit use_reset);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = a; PWDATA = d; PSTRB = 4'hF; PPROT = 3'b000;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        if (use_reset) begin
            PRESETn = 1'b0;
            #1;
            check({tag, ":rst_pready"}, {31'b0, PREADY}, 32'h0);
            check({tag, ":rst_prdata"}, PRDATA, 32'h0);
            @(negedge PCLK);
            PSEL = 1'b0; PENABLE = 1'b0;
            @(negedge PCLK);
            PRESETn = 1'b1;
        end else begin
            PSEL = 1'b0; PENABLE = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge PCLK);
                check({tag, ":abort_pready"}, {31'b0, PREADY}, 32'h0);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge PCLK);
        check("reset_pready", {31'b0, PREADY}, 32'h0);
        check("reset_prdata", PRDATA, 32'h0);
        check("reset_pslverr", {31'b0, PSLVERR}, 32'h0);
        PRESETn = 1'b1;

        xfer("wr_basic", 1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000);
        go_idle();
        xfer("rd_basic", 0, 16'h0010, 32'h0, 4'h0, 3'b000);
        go_idle();

        xfer("wr_partial", 1, 16'h0010, 32'h00001234, 4'b0011, 3'b000);
        xfer("rd_partial", 0, 16'h0010, 32'h0, 4'h0, 3'b000);

        xfer("wr_misalign", 1, 16'h0011, 32'hFFFFFFFF, 4'hF, 3'b000);
        xfer("rd_after_misalign", 0, 16'h0010, 32'h0, 4'h0, 3'b000);

        xfer("wr_0004", 1, 16'h0004, 32'h04040404, 4'hF, 3'b000);
        xfer("wr_priv_noprot", 1, 16'h8004, 32'h5A5A5A5A, 4'hF, 3'b000);
        xfer("wr_priv", 1, 16'h8004, 32'hA5A5A5A5, 4'hF, 3'b111);
        xfer("rd_priv", 0, 16'h8004, 32'h0, 4'h0, 3'b111);
        xfer("rd_0004", 0, 16'h0004, 32'h0, 4'h0, 3'b000);
        xfer("rd_strb_fault", 0, 16'h0004, 32'h0, 4'h1, 3'b000);
        go_idle();

        xfer("b2b_wr0", 1, 16'h0000, 32'h10101010, 4'hF, 3'b000);
        xfer("b2b_wr4", 1, 16'h0004, 32'h20202020, 4'hF, 3'b000);
        xfer("b2b_wr8", 1, 16'h0008, 32'h30303030, 4'hF, 3'b000);
        xfer("b2b_rd0", 0, 16'h0000, 32'h0, 4'h0, 3'b000);
        xfer("b2b_rd4", 0, 16'h0004, 32'h0, 4'h0, 3'b000);
        xfer("b2b_rd8", 0, 16'h0008, 32'h0, 4'h0, 3'b000);
        xfer("wr_c", 1, 16'h000C, 32'hCAFEF00D, 4'hF, 3'b000);
        xfer("rd_c", 0, 16'h000C, 32'h0, 4'h0, 3'b000);
        go_idle();

        xfer("wr_20", 1, 16'h0020, 32'h22222222, 4'hF, 3'b000);
        go_idle();
        xfer_abort("reset_abort", 16'h0020, 32'h11111111, 1'b1);
        xfer("rd_20_after_reset", 0, 16'h0020, 32'h0, 4'h0, 3'b000);
        go_idle();
        xfer_abort("psel_abort", 16'h0020, 32'h33333333, 1'b0);
        xfer("rd_20_after_abort", 0, 16'h0020, 32'h0, 4'h0, 3'b000);
        xfer("wr_20_again", 1, 16'h0020, 32'h44444444, 4'hF, 3'b000);
        xfer("rd_20_again", 0, 16'h0020, 32'h0, 4'h0, 3'b000);

        for (int i = 0; i < 16; i++) begin
            logic [15:0] a;
            bit          wr;
            logic [3:0]  s;
            logic [2:0]  p;
            a  = 16'($urandom_range(0, 3) * 4);
            wr = 1'($urandom);
            s  = wr ? 4'($urandom) : (($urandom_range(0, 3) == 0) ? 4'h2 : 4'h0);
            p  = ($urandom_range(0, 4) == 0) ? 3'b111 : 3'b000;
            xfer($sformatf("rand%0d", i), wr, a, $urandom, s, p);
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
